multicycle_ctrl_fsm: RTL and testbench

//  Main control FSM sequencing a shared-memory multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal, jalr).

---
 rtl/multicycle_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for a shared-memory multicycle RV32I datapath.
// Drives the PC and IR enables, the ALU operand and result muxes, and the
// register-file write. It also runs a req/ready handshake with a single
// unified memory, and a wait timeout aborts a stalled memory access.
// Optional feature: define ILLEGAL_TRAP_EN so that an unknown opcode halts
// the FSM in TRAP with illegal_instr set. Without it, an unknown opcode is a
// NOP.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       mem_err,
  output logic       illegal_instr
);

  // The counter only needs to reach MEM_TIMEOUT-1; the abort fires on the next low cycle.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_hit;
  logic             pc_update;
  logic             branch;
  logic [1:0]       imm_dec;

  // The timeout fires only on a low-ready cycle, so a late mem_ready always completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LAST);

  // Immediate format decode, which follows op directly.
  always_comb begin
    imm_dec = 2'b00;
    case (op)
      OP_SW:   imm_dec = 2'b01;
      OP_BEQ:  imm_dec = 2'b10;
      OP_JAL:  imm_dec = 2'b11;
      default: imm_dec = 2'b00;
    endcase
  end

  // State register and memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic and the output decode for each state.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    imm_src       = imm_dec;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    mem_err       = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      S_RST: begin
        imm_src = 2'b00;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          // A fetch abort leaves pc alone, so the same address is retried.
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        branch        = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        imm_src = 2'b00;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        state_d       = S_TRAP;
`else
        state_d       = S_FETCH;
`endif
      end
      default: begin
        imm_src = 2'b00;
        state_d = S_RST;
      end
    endcase

    pc_write = pc_update | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each cycle pushes the expected
// output vector into a scoreboard, and a negedge monitor pops it and compares.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TO = 8;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  typedef enum {
    T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_JALR, T_TRAP
  } tst_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       retired;
    logic       mem_err;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic       reg_write, instr_retired, mem_err, illegal_instr;
  outs_t      got;

  int    checks = 0;
  int    errors = 0;
  outs_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .imm_src(imm_src), .reg_write(reg_write), .instr_retired(instr_retired),
    .mem_err(mem_err), .illegal_instr(illegal_instr)
  );

  assign got = '{mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a,
                 alu_src_b, alu_op, result_src, imm_src, reg_write,
                 instr_retired, mem_err, illegal_instr};

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected outputs for a state, taken from the control table.
  function automatic outs_t model(input tst_e s, input logic [6:0] o, input logic z,
                                  input logic rdy, input logic ab);
    outs_t e;
    e = '0;
    e.imm_src = imm_of(o);
    case (s)
      T_RST:      e.imm_src = 2'b00;
      T_FETCH:    begin e.mem_req = 1'b1; e.src_b = 2'b10; e.result_src = 2'b10;
                        e.ir_write = rdy; e.pc_write = rdy; e.mem_err = ab; end
      T_DECODE:   begin e.src_a = 2'b01; e.src_b = 2'b01; end
      T_MEMADR:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
      T_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_err = ab; end
      T_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; e.retired = 1'b1; end
      T_MEMWRITE: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1;
                        e.retired = rdy; e.mem_err = ab; end
      T_EXECR:    begin e.src_a = 2'b10; e.alu_op = 2'b10; end
      T_EXECI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
      T_ALUWB:    begin e.reg_write = 1'b1; e.retired = 1'b1; end
      T_BEQ:      begin e.src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; e.retired = 1'b1; end
      T_JALR:     begin e.src_a = 2'b10; e.src_b = 2'b01; end
      T_JAL:      begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
      T_TRAP:     begin e = '0; e.illegal = 1'b1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the expectation.
  task automatic step(input tst_e s, input logic rst, input logic [6:0] o,
                      input logic z, input logic rdy, input logic ab);
    @(posedge clk);
    #1;
    reset     = rst;
    op        = o;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(model(s, o, z, rdy, ab));
    tag_q.push_back(s.name());
  endtask

  // A non-memory cycle: mem_ready and zero must not matter, so randomise them.
  task automatic nstep(input tst_e s, input logic [6:0] o);
    step(s, 1'b0, o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic fetch1(input logic [6:0] o);
    step(T_FETCH, 1'b0, o, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      outs_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(got), 32'(e));
    end
  end

  initial begin
    // Reset held, then released with the FSM still in RST
    step(T_RST, 1'b1, OP_R, 1'b0, 1'b0, 1'b0);
    step(T_RST, 1'b1, OP_R, 1'b0, 1'b1, 1'b0);
    step(T_RST, 1'b0, OP_R, 1'b0, 1'b0, 1'b0);

    // lw: two fetch waits, one read wait
    step(T_FETCH, 1'b0, OP_LW, 1'b0, 1'b0, 1'b0);
    step(T_FETCH, 1'b0, OP_LW, 1'b0, 1'b0, 1'b0);
    step(T_FETCH, 1'b0, OP_LW, 1'b0, 1'b1, 1'b0);
    nstep(T_DECODE, OP_LW);
    nstep(T_MEMADR, OP_LW);
    step(T_MEMREAD, 1'b0, OP_LW, 1'b0, 1'b0, 1'b0);
    step(T_MEMREAD, 1'b0, OP_LW, 1'b0, 1'b1, 1'b0);
    nstep(T_MEMWB, OP_LW);

    // beq taken, then not taken
    fetch1(OP_BEQ); nstep(T_DECODE, OP_BEQ);
    step(T_BEQ, 1'b0, OP_BEQ, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    fetch1(OP_BEQ); nstep(T_DECODE, OP_BEQ);
    step(T_BEQ, 1'b0, OP_BEQ, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // jalr, jal, R-type, I-type
    fetch1(OP_JALR); nstep(T_DECODE, OP_JALR); nstep(T_JALR, OP_JALR);
    nstep(T_JAL, OP_JALR); nstep(T_ALUWB, OP_JALR);
    fetch1(OP_JAL); nstep(T_DECODE, OP_JAL); nstep(T_JAL, OP_JAL); nstep(T_ALUWB, OP_JAL);
    fetch1(OP_R); nstep(T_DECODE, OP_R); nstep(T_EXECR, OP_R); nstep(T_ALUWB, OP_R);
    fetch1(OP_I); nstep(T_DECODE, OP_I); nstep(T_EXECI, OP_I); nstep(T_ALUWB, OP_I);

    // sw with one wait, then completion
    fetch1(OP_SW); nstep(T_DECODE, OP_SW); nstep(T_MEMADR, OP_SW);
    step(T_MEMWRITE, 1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_MEMWRITE, 1'b0, OP_SW, 1'b0, 1'b1, 1'b0);

    // sw with mem_ready stuck low: abort on the TO-th low cycle
    fetch1(OP_SW); nstep(T_DECODE, OP_SW); nstep(T_MEMADR, OP_SW);
    for (int i = 0; i < int'(TO) - 1; i++) step(T_MEMWRITE, 1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_MEMWRITE, 1'b0, OP_SW, 1'b0, 1'b0, 1'b1);
    fetch1(OP_R); nstep(T_DECODE, OP_R); nstep(T_EXECR, OP_R); nstep(T_ALUWB, OP_R);

    // fetch timeout, then a retry that succeeds
    for (int i = 0; i < int'(TO) - 1; i++) step(T_FETCH, 1'b0, OP_I, 1'b0, 1'b0, 1'b0);
    step(T_FETCH, 1'b0, OP_I, 1'b0, 1'b0, 1'b1);
    fetch1(OP_I); nstep(T_DECODE, OP_I); nstep(T_EXECI, OP_I); nstep(T_ALUWB, OP_I);

    // lw whose mem_ready arrives on the TO-th cycle: normal completion wins
    fetch1(OP_LW); nstep(T_DECODE, OP_LW); nstep(T_MEMADR, OP_LW);
    for (int i = 0; i < int'(TO) - 1; i++) step(T_MEMREAD, 1'b0, OP_LW, 1'b0, 1'b0, 1'b0);
    step(T_MEMREAD, 1'b0, OP_LW, 1'b0, 1'b1, 1'b0);
    nstep(T_MEMWB, OP_LW);

    // Illegal opcode
    fetch1(OP_ILL); nstep(T_DECODE, OP_ILL);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) nstep(T_TRAP, OP_ILL);
    step(T_RST, 1'b1, OP_R, 1'b0, 1'b0, 1'b0);
    step(T_RST, 1'b0, OP_R, 1'b0, 1'b0, 1'b0);
`endif
    fetch1(OP_R); nstep(T_DECODE, OP_R); nstep(T_EXECR, OP_R); nstep(T_ALUWB, OP_R);

    // Reset during a pending store: outputs drop within the cycle
    fetch1(OP_SW); nstep(T_DECODE, OP_SW); nstep(T_MEMADR, OP_SW);
    step(T_MEMWRITE, 1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_RST, 1'b1, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_RST, 1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_FETCH, 1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
    step(T_FETCH, 1'b0, OP_SW, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
